led_cube_frame_fetcher: RTL and testbench

- Avalon-MM read master that pulls 64-byte cube frames from external memory and streams them, one byte per beat, into the cube controller's stream-mode input (data_in / readdatavalid pair).
- Paces fetches with a frame-period timer and walks an animation of NUM_FRAMES frames, wrapping to frame 0.
- Sits between the SDRAM/bridge master port and the cube controller running in stream mode (mode 4'h3).

---
 rtl/led_cube_pkg.sv | 19 +
 rtl/led_cube_pend_counter.sv | 32 +++
 rtl/led_cube_frame_fetcher.sv | 187 ++++++++++++++++++
 tb/tb_led_cube_frame_fetcher.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_cube_pkg.sv
// Shared types and constants for the LED cube frame fetch path.
//   frame_state_e : frame fetcher sequencing states
//   FRAME_BYTES   : bytes in one cube frame (8 layers x 8 latches)
//   STREAM_MODE   : cube controller mode value that consumes this byte stream
package led_cube_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_RESP,
    WAIT_TICK,
    DRAIN
  } frame_state_e;

  localparam int FRAME_BYTES = 64;

  localparam logic [3:0] STREAM_MODE = 4'h3;

endpackage

// File: rtl/led_cube_pend_counter.sv
// Outstanding read request counter.
//   clk, rst_n : clock, async active-low reset
//   inc        : a request was accepted this cycle
//   dec        : a response returned this cycle
//   cnt        : requests accepted but not yet answered
//   full       : cnt has reached MAX_PEND
module led_cube_pend_counter #(
  parameter int MAX_PEND = 4,
  parameter int CNT_W    = $clog2(MAX_PEND + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             full
);

  // inc and dec together leave the count unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && !dec) begin
      cnt <= cnt + CNT_W'(1);
    end else if (dec && !inc) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign full = (cnt == CNT_W'(MAX_PEND));

endmodule

// File: rtl/led_cube_frame_fetcher.sv
// Avalon-MM read master that fetches cube frames byte by byte from memory and
// streams them to the cube controller's stream-mode input, one frame per
// frame period, cycling through NUM_FRAMES frames.
//   clk, rst_n        : clock, async active-low reset
//   start / stop      : one-cycle pulses; stop wins when both are high
//   base_addr         : byte address of frame 0, captured on start
//   avm_*             : Avalon-MM read master (address, read, waitrequest,
//                       readdata, readdatavalid)
//   data_out/data_valid : registered byte stream to the cube controller
//   frame_sync        : marks the first byte of each frame
//   busy              : fetcher is not idle
//   overrun           : sticky, a frame tick arrived while still fetching
//
// state     | meaning
// IDLE      | stopped, waiting for start
// ISSUE     | issuing the frame's read requests
// WAIT_RESP | all requests accepted, collecting the remaining bytes
// WAIT_TICK | frame complete, waiting for the next frame period tick
// DRAIN     | stopped, swallowing responses still in flight
module led_cube_frame_fetcher #(
  parameter int ADDR_W       = 32,
  parameter int FRAME_BYTES  = led_cube_pkg::FRAME_BYTES,
  parameter int NUM_FRAMES   = 150,
  parameter int FRAME_PERIOD = 1500000,
  parameter int MAX_PEND     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] base_addr,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [7:0]        avm_readdata,
  input  logic              avm_readdatavalid,
  output logic [7:0]        data_out,
  output logic              data_valid,
  output logic              frame_sync,
  output logic              busy,
  output logic              overrun
);
  import led_cube_pkg::*;

  localparam int PEND_W = $clog2(MAX_PEND + 1);
  localparam int BYTE_W = $clog2(FRAME_BYTES);
  localparam int FIDX_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam int TMR_W  = $clog2(FRAME_PERIOD);

  localparam logic [TMR_W-1:0]  TMR_LOAD   = TMR_W'(FRAME_PERIOD - 1);
  localparam logic [BYTE_W-1:0] LAST_BYTE  = BYTE_W'(FRAME_BYTES - 1);
  localparam logic [FIDX_W-1:0] LAST_FRAME = FIDX_W'(NUM_FRAMES - 1);

  frame_state_e      state;
  logic [BYTE_W-1:0] req_cnt;
  logic [BYTE_W-1:0] resp_cnt;
  logic [FIDX_W-1:0] frame_idx;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] frame_addr;
  logic [TMR_W-1:0]  tmr;
  logic [PEND_W-1:0] pend_cnt;
  logic              pend_full;
  logic              accept;
  logic              running;
  logic              fetching;
  logic              tick;
  logic              drain_done;

  led_cube_pend_counter #(
    .MAX_PEND (MAX_PEND),
    .CNT_W    (PEND_W)
  ) u_pend (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (accept),
    .dec   (avm_readdatavalid),
    .cnt   (pend_cnt),
    .full  (pend_full)
  );

  // Request side decodes only from registers, so while the slave stalls the
  // address and read strobe cannot move: req_cnt needs an accept to advance
  // and pend can only fall.
  assign avm_read    = (state == ISSUE) && !pend_full;
  assign avm_address = frame_addr + ADDR_W'(req_cnt);
  assign accept      = avm_read && !avm_waitrequest;

  assign running  = (state == ISSUE) || (state == WAIT_RESP) || (state == WAIT_TICK);
  assign fetching = (state == ISSUE) || (state == WAIT_RESP);
  // Frame period timer counts down; reaching zero is the tick.
  assign tick     = running && (tmr == '0);

  // Leave DRAIN on the cycle of the last response rather than one later.
  assign drain_done = (pend_cnt == '0) || ((pend_cnt == PEND_W'(1)) && avm_readdatavalid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_cnt    <= '0;
      resp_cnt   <= '0;
      frame_idx  <= '0;
      base_q     <= '0;
      frame_addr <= '0;
      tmr        <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_sync <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      data_out   <= avm_readdata;
      data_valid <= avm_readdatavalid && fetching;
      frame_sync <= avm_readdatavalid && fetching && (resp_cnt == '0);

      if (running) begin
        tmr <= tick ? TMR_LOAD : tmr - TMR_W'(1);
      end
      // A tick while still fetching is lost; the frame waits for the next one.
      if (tick && fetching) begin
        overrun <= 1'b1;
      end
      if (accept) begin
        req_cnt <= req_cnt + BYTE_W'(1);
      end
      if (avm_readdatavalid && fetching) begin
        resp_cnt <= resp_cnt + BYTE_W'(1);
      end

      case (state)
        IDLE: begin
          if (start && !stop) begin
            state      <= ISSUE;
            busy       <= 1'b1;
            overrun    <= 1'b0;
            tmr        <= TMR_LOAD;
            base_q     <= base_addr;
            frame_addr <= base_addr;
            frame_idx  <= '0;
            req_cnt    <= '0;
            resp_cnt   <= '0;
          end
        end
        ISSUE: begin
          if (stop) begin
            state <= DRAIN;
          end else if (accept && (req_cnt == LAST_BYTE)) begin
            state   <= WAIT_RESP;
            req_cnt <= '0;
          end
        end
        WAIT_RESP: begin
          if (stop) begin
            state <= DRAIN;
          end else if (avm_readdatavalid && (resp_cnt == LAST_BYTE)) begin
            state    <= WAIT_TICK;
            resp_cnt <= '0;
            if (frame_idx == LAST_FRAME) begin
              frame_idx  <= '0;
              frame_addr <= base_q;
            end else begin
              frame_idx  <= frame_idx + FIDX_W'(1);
              frame_addr <= frame_addr + ADDR_W'(FRAME_BYTES);
            end
          end
        end
        WAIT_TICK: begin
          if (stop) begin
            state <= DRAIN;
          end else if (tick) begin
            state <= ISSUE;
          end
        end
        DRAIN: begin
          if (drain_done) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_cube_frame_fetcher.sv
module tb_led_cube_frame_fetcher;

  localparam int NF  = 3;
  localparam int PER = 300;
  localparam int MP  = 4;
  localparam int FB  = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic [31:0] base_addr;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [7:0]  avm_readdata;
  logic        avm_readdatavalid;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        frame_sync;
  logic        busy;
  logic        overrun;

  always #5 clk = ~clk;

  led_cube_frame_fetcher #(
    .ADDR_W       (32),
    .FRAME_BYTES  (FB),
    .NUM_FRAMES   (NF),
    .FRAME_PERIOD (PER),
    .MAX_PEND     (MP)
  ) u_dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .stop              (stop),
    .base_addr         (base_addr),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .data_out          (data_out),
    .data_valid        (data_valid),
    .frame_sync        (frame_sync),
    .busy              (busy),
    .overrun           (overrun)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // slave model and stream monitor state
  int          cyc = 0;
  int          lat = 2;
  int          wait_cyc = 0;
  int          st_cnt = 0;
  int          out_n = 0;
  int          max_out = 0;
  int          acc_n = 0;
  int          beat_n = 0;
  int          drain_resp_n = 0;
  int          start_cyc = 0;
  logic        stalled_q = 1'b0;
  logic [31:0] stall_addr = '0;
  logic [31:0] run_base = '0;
  logic        drain_f = 1'b0;
  logic        prev_live = 1'b0;
  int          t_start [8];
  logic [31:0] f_addr [8];
  logic [31:0] rq_addr [$];
  int          rq_due [$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [31:0] exp_addr(input int n);
    return run_base + 32'(((n / FB) % NF) * FB + (n % FB));
  endfunction

  // One clock of slave + monitor, evaluated at the falling edge.
  task automatic step();
    logic        live;
    logic [31:0] a;
    @(negedge clk);
    cyc++;
    check("data_valid", data_valid, prev_live);
    if (prev_live) begin
      check("data_out", data_out, mem_byte(exp_addr(beat_n)));
      check("frame_sync", frame_sync, (beat_n % FB) == 0);
      beat_n++;
    end else begin
      check("frame_sync_quiet", frame_sync, 0);
    end
    if (stalled_q) begin
      check("hold_read", avm_read, 1);
      check("hold_addr", avm_address, stall_addr);
    end
    if (out_n == MP) check("read_when_full", avm_read, 0);
    live = 1'b0;
    if (rq_due.size() > 0 && rq_due[0] == cyc) begin
      a = rq_addr.pop_front();
      void'(rq_due.pop_front());
      avm_readdatavalid = 1'b1;
      avm_readdata = mem_byte(a);
      out_n--;
      live = !drain_f;
      if (drain_f) drain_resp_n++;
    end else begin
      avm_readdatavalid = 1'b0;
      avm_readdata = 8'h00;
    end
    prev_live = live;
    if (avm_read && st_cnt < wait_cyc) begin
      avm_waitrequest = 1'b1;
      st_cnt++;
    end else begin
      avm_waitrequest = 1'b0;
      st_cnt = 0;
    end
    if (avm_read && !avm_waitrequest) begin
      check("req_addr", avm_address, exp_addr(acc_n));
      if ((acc_n % FB) == 0 && (acc_n / FB) < 8) begin
        t_start[acc_n / FB] = cyc;
        f_addr[acc_n / FB] = avm_address;
      end
      rq_addr.push_back(avm_address);
      rq_due.push_back(cyc + lat);
      out_n++;
      acc_n++;
      if (out_n > max_out) max_out = out_n;
    end
    stalled_q = avm_read && avm_waitrequest;
    stall_addr = avm_address;
  endtask

  task automatic begin_run(input logic [31:0] base, input int l, input int w);
    run_base = base;
    lat = l;
    wait_cyc = w;
    acc_n = 0;
    beat_n = 0;
    max_out = 0;
    drain_f = 1'b0;
    drain_resp_n = 0;
    for (int i = 0; i < 8; i++) begin
      t_start[i] = -1;
      f_addr[i] = '0;
    end
    base_addr = base;
    start = 1'b1;
    start_cyc = cyc;
    step();
    start = 1'b0;
    base_addr = 32'hDEAD_BEEF;
  endtask

  task automatic wait_beats(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (beat_n < n && k < budget) begin
      step();
      k++;
    end
    check({tag, "_beats"}, beat_n, n);
  endtask

  task automatic stop_and_idle(input string tag);
    int k;
    stop = 1'b1;
    drain_f = 1'b1;
    drain_resp_n = 0;
    step();
    stop = 1'b0;
    k = 0;
    while (busy && k < 100) begin
      check({tag, "_drain_read"}, avm_read, 0);
      step();
      k++;
    end
    check({tag, "_idle"}, busy, 0);
    check({tag, "_outstanding"}, out_n, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    base_addr = '0;
    avm_waitrequest = 1'b0;
    avm_readdata = 8'h00;
    avm_readdatavalid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      t_start[i] = -1;
      f_addr[i] = '0;
    end

    // reset
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_read", avm_read, 0);
    check("rst_addr", avm_address, 0);
    rst_n = 1'b1;
    step();
    check("rst_overrun", overrun, 0);
    check("rst_data_out", data_out, 0);
    check("rst_frame_sync", frame_sync, 0);
    check("rst_busy_after", busy, 0);

    // four frames, no stall, latency 2, animation wraps after NF frames
    begin_run(32'h0000_1000, 2, 0);
    check("t2_first_issue", t_start[0] - start_cyc, 1);
    check("t2_busy", busy, 1);
    wait_beats(4 * FB, 1500, "t2");
    check("t2_addr_f0", f_addr[0], 32'h0000_1000);
    check("t2_addr_f1", f_addr[1], 32'h0000_1040);
    check("t2_addr_f3_wrap", f_addr[3], 32'h0000_1000);
    check("t2_period_01", t_start[1] - t_start[0], PER);
    check("t2_period_12", t_start[2] - t_start[1], PER);
    check("t2_period_23", t_start[3] - t_start[2], PER);
    check("t2_pend_bound", max_out <= MP, 1);
    check("t2_overrun", overrun, 0);
    stop_and_idle("t2");

    // 3-cycle waitrequest on every request
    begin_run(32'h0000_2000, 2, 3);
    wait_beats(FB, 400, "t3");
    repeat (5) step();
    check("t3_accepts", acc_n, FB);
    check("t3_beats_final", beat_n, FB);
    check("t3_pend_bound", max_out <= MP, 1);
    check("t3_overrun", overrun, 0);
    stop_and_idle("t3");

    // latency 20: pend saturates, fetch outlasts the period
    begin_run(32'h0000_3000, 20, 0);
    wait_beats(FB, 500, "t4");
    check("t4_max_pend", max_out, MP);
    check("t4_overrun", overrun, 1);
    begin
      int k;
      k = 0;
      while (acc_n < FB + 1 && k < 400) begin
        step();
        k++;
      end
    end
    check("t4_next_frame_2per", t_start[1] - t_start[0], 2 * PER);
    check("t4_next_addr", f_addr[1], 32'h0000_3040);
    stop_and_idle("t4");
    check("t4_overrun_sticky", overrun, 1);

    // stop with three reads pending
    begin_run(32'h0000_4000, 20, 0);
    check("t5_overrun_cleared", overrun, 0);
    begin
      int k;
      k = 0;
      while (acc_n < 3 && k < 10) begin
        step();
        k++;
      end
    end
    check("t5_pending", out_n, 3);
    stop = 1'b1;
    drain_f = 1'b1;
    drain_resp_n = 0;
    step();
    stop = 1'b0;
    check("t5_no_read", avm_read, 0);
    begin
      int k;
      k = 0;
      while (k < 60) begin
        step();
        k++;
        check("t5_drain_read", avm_read, 0);
        if (avm_readdatavalid && out_n == 0) begin
          check("t5_busy_at_last", busy, 1);
          step();
          check("t5_busy_after_last", busy, 0);
          break;
        end
      end
    end
    check("t5_drain_resp", drain_resp_n, 3);
    check("t5_accepts", acc_n, 3);
    repeat (3) step();

    // start and stop together from idle: stop wins
    start = 1'b1;
    stop = 1'b1;
    base_addr = 32'h0000_5000;
    step();
    start = 1'b0;
    stop = 1'b0;
    step();
    check("t6_busy", busy, 0);
    check("t6_read", avm_read, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
